// File: rtl/pn_pkg.sv
// Shared definitions for the PN sequence checker.
//   pn_state_t   : checker FSM states
//   PN_POL_W     : default PN generator state width (x^7+x^6+1)
//   PN_POL_MASK  : default tap mask over {state, new bit}
package pn_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } pn_state_t;

  localparam int              PN_POL_W    = 7;
  localparam logic [PN_POL_W:0] PN_POL_MASK = 8'hC0;

endpackage

// File: rtl/pn_popcount.sv
// Population count of a DW-bit vector.
// Ports:
//   bits  : input vector
//   count : number of ones in bits
module pn_popcount #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]            bits,
  output logic [$clog2(DW+1)-1:0]  count
);

  localparam int CW = $clog2(DW + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < DW; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/pn_checker.sv
// PN sequence checker: acquires lock on an incoming PN word stream, then
// counts bit errors against a free-running local generator.
// Ports:
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   rx_valid  : qualifies rx_data
//   rx_data   : received word, bit DW-1 oldest, bit 0 newest
//   cnt_clear : clears err_count
//   locked    : high while in LOCKED
//   err_valid : one-cycle pulse qualifying err_bits
//   err_bits  : mismatched bits in the last checked word
//   err_count : saturating total of bit errors seen while locked
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SEARCH | seed from each word, count consecutive predicted matches
// ST_LOCKED | compare against local generator, count errors
module pn_checker
  import pn_pkg::*;
#(
  parameter int              POL_W     = PN_POL_W,
  parameter logic [POL_W:0]  POL_MASK  = PN_POL_MASK,
  parameter int              DW        = 16,
  parameter int              LOCK_CNT  = 4,
  parameter int              ERR_LIMIT = 4,
  parameter int              CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [DW-1:0]             rx_data,
  input  logic                      cnt_clear,
  output logic                      locked,
  output logic                      err_valid,
  output logic [$clog2(DW+1)-1:0]   err_bits,
  output logic [CNT_W-1:0]          err_count
);

  localparam int EW = $clog2(DW + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  // Sum width wide enough for either operand plus a carry.
  localparam int SW = ((CNT_W > EW) ? CNT_W : EW) + 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(ERR_LIMIT - 1);
  localparam logic [SW-1:0] CNT_MAX    = SW'({CNT_W{1'b1}});

  // Generates one word from a seed, oldest bit first; each new bit depends
  // only on bits already produced (tap mask bit 0 is the bit itself).
  function automatic logic [DW-1:0] pn_pred(input logic [POL_W-1:0] seed);
    logic [POL_W+DW-1:0] f;
    f = {seed, {DW{1'b0}}};
    for (int i = DW - 1; i >= 0; i--) begin
      f[i] = ^(f[i +: POL_W+1] & POL_MASK);
    end
    return f[DW-1:0];
  endfunction

  pn_state_t         state;
  logic [POL_W-1:0]  prev;
  logic [POL_W-1:0]  lstate;
  logic              prev_ok;
  logic [MW-1:0]     match_cnt;
  logic [BW-1:0]     bad_cnt;

  logic [DW-1:0]     pred_prev;
  logic [DW-1:0]     pred_loc;
  logic              search_hit;
  logic [EW-1:0]     pop;
  logic [SW-1:0]     cnt_base;
  logic [SW-1:0]     cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  assign pred_prev  = pn_pred(prev);
  assign pred_loc   = pn_pred(lstate);
  assign search_hit = (rx_data == pred_prev) && (rx_data != '0);
  assign locked     = (state == ST_LOCKED);

  pn_popcount #(.DW(DW)) u_popcount (
    .bits  (rx_data ^ pred_loc),
    .count (pop)
  );

  // A clear coinciding with an update restarts the total from this word.
  assign cnt_base = cnt_clear ? '0 : SW'(err_count);
  assign cnt_sum  = cnt_base + SW'(pop);
  assign cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      prev      <= '0;
      lstate    <= '0;
      prev_ok   <= 1'b0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      err_valid <= 1'b0;
      err_bits  <= '0;
    end else begin
      err_valid <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_SEARCH: begin
            prev    <= rx_data[POL_W-1:0];
            prev_ok <= 1'b1;
            if (prev_ok && search_hit) begin
              if (match_cnt == MATCH_LAST) begin
                state     <= ST_LOCKED;
                lstate    <= rx_data[POL_W-1:0];
                match_cnt <= '0;
                bad_cnt   <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Local generator free-runs; received bits never feed back.
            lstate    <= pred_loc[POL_W-1:0];
            err_valid <= 1'b1;
            err_bits  <= pop;
            if (pop != '0) begin
              if (bad_cnt == BAD_LAST) begin
                state     <= ST_SEARCH;
                match_cnt <= '0;
                prev_ok   <= 1'b0;
                bad_cnt   <= '0;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (rx_valid && (state == ST_LOCKED)) begin
      err_count <= cnt_next;
    end else if (cnt_clear) begin
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_pn_checker.sv
module tb_pn_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        cnt_clear = 1'b0;

  logic        locked, err_valid;
  logic [4:0]  err_bits;
  logic [31:0] err_count;
  logic        locked_s, err_valid_s;
  logic [4:0]  err_bits_s;
  logic [3:0]  err_count_s;

  int checks = 0;
  int errors = 0;

  pn_checker dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cnt_clear(cnt_clear), .locked(locked), .err_valid(err_valid),
    .err_bits(err_bits), .err_count(err_count)
  );

  pn_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cnt_clear(cnt_clear), .locked(locked_s), .err_valid(err_valid_s),
    .err_bits(err_bits_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  // Reference model: behaviour of the checker described as words and counts.
  bit              m_locked;
  bit              m_prev_ok;
  logic [6:0]      m_prev, m_loc;
  int              m_match, m_bad;
  longint unsigned m_cnt_a, m_cnt_s;
  bit              exp_ev;
  int              exp_eb;
  logic [6:0]      g;

  // PRBS7 bit by bit: b[n] = b[n-7] ^ b[n-6]; first produced bit is the oldest.
  function automatic logic [15:0] model_next(input logic [6:0] seed);
    bit q[$];
    logic [15:0] w;
    bit b;
    w = '0;
    for (int k = 6; k >= 0; k--) q.push_back(seed[k]);
    for (int n = 0; n < 16; n++) begin
      b = q[q.size()-7] ^ q[q.size()-6];
      q.push_back(b);
      w[15-n] = b;
    end
    return w;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step(input logic v, input logic [15:0] d, input logic c, input logic r);
    logic [15:0] p;
    exp_ev = 1'b0;
    if (r) begin
      m_locked = 0; m_prev_ok = 0; m_prev = '0; m_loc = '0;
      m_match = 0; m_bad = 0; m_cnt_a = 0; m_cnt_s = 0; exp_eb = 0;
    end else if (!m_locked) begin
      if (v) begin
        if (m_prev_ok && d == model_next(m_prev) && d != 16'h0000) m_match++;
        else m_match = 0;
        if (m_match == 4) begin
          m_locked = 1; m_loc = d[6:0]; m_match = 0; m_bad = 0;
        end
        m_prev = d[6:0];
        m_prev_ok = 1;
      end
      if (c) begin m_cnt_a = 0; m_cnt_s = 0; end
    end else begin
      if (v) begin
        p = model_next(m_loc);
        m_loc = p[6:0];
        exp_ev = 1'b1;
        exp_eb = $countones(d ^ p);
        m_cnt_a = sat((c ? 0 : m_cnt_a) + longint'(exp_eb), 64'hFFFF_FFFF);
        m_cnt_s = sat((c ? 0 : m_cnt_s) + longint'(exp_eb), 15);
        if (exp_eb != 0) begin
          m_bad++;
          if (m_bad == 4) begin
            m_locked = 0; m_match = 0; m_prev_ok = 0; m_bad = 0;
          end
        end else begin
          m_bad = 0;
        end
      end else if (c) begin
        m_cnt_a = 0; m_cnt_s = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic c, input logic r);
    rx_valid = v; rx_data = d; cnt_clear = c; rst = r;
    model_step(v, d, c, r);
    @(posedge clk);
    #1;
    check("locked", 64'(locked), 64'(m_locked));
    check("locked_s", 64'(locked_s), 64'(m_locked));
    check("err_valid", 64'(err_valid), 64'(exp_ev));
    if (exp_ev) check("err_bits", 64'(err_bits), 64'(exp_eb));
    check("err_count", 64'(err_count), m_cnt_a);
    check("err_count_s", 64'(err_count_s), m_cnt_s);
    rx_valid = 1'b0; cnt_clear = 1'b0; rst = 1'b0;
  endtask

  // Random idle gap (state must hold), then one valid word.
  task automatic send(input logic [15:0] d, input logic c);
    repeat ($urandom_range(0, 2)) step(1'b0, 16'($urandom), 1'b0, 1'b0);
    step(1'b1, d, c, 1'b0);
  endtask

  task automatic gen_word(output logic [15:0] w);
    w = model_next(g);
    g = w[6:0];
  endtask

  initial begin
    logic [15:0] w;
    int burst;

    // Reset
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_bits", 64'(err_bits), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);

    // Lock acquisition from state 7F
    g = 7'h7F;
    for (int k = 1; k <= 6; k++) begin
      gen_word(w);
      send(w, 1'b0);
      if (k == 4) check("acq_not_yet", 64'(locked), 64'd0);
      if (k == 5) check("acq_locked", 64'(locked), 64'd1);
      if (k == 6) begin
        check("acq_err_valid", 64'(err_valid), 64'd1);
        check("acq_err_bits", 64'(err_bits), 64'd0);
        check("acq_err_count", 64'(err_count), 64'd0);
      end
    end

    // Single bit error on rx_data[3]
    gen_word(w);
    send(w ^ 16'h0008, 1'b0);
    check("sbe_err_bits", 64'(err_bits), 64'd1);
    check("sbe_err_count", 64'(err_count), 64'd1);
    gen_word(w);
    send(w, 1'b0);
    check("sbe_next_bits", 64'(err_bits), 64'd0);
    check("sbe_locked", 64'(locked), 64'd1);

    // One short of the error limit keeps lock
    for (int k = 0; k < 3; k++) begin gen_word(w); send(~w, 1'b0); end
    gen_word(w);
    send(w, 1'b0);
    check("limit_minus1_locked", 64'(locked), 64'd1);
    check("limit_minus1_count", 64'(err_count), 64'd49);

    // Lock loss after four inverted words
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("idle_clear", 64'(err_count), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      gen_word(w);
      send(~w, 1'b0);
      if (k == 3) check("loss_still_locked", 64'(locked), 64'd1);
    end
    check("loss_err_count", 64'(err_count), 64'd64);
    check("loss_locked", 64'(locked), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      gen_word(w);
      send(w, 1'b0);
      if (k == 4) check("reacq_not_yet", 64'(locked), 64'd0);
      if (k == 5) check("reacq_locked", 64'(locked), 64'd1);
    end

    // Saturation on the 4-bit counter and clear coinciding with an update
    step(1'b0, 16'h0, 1'b1, 1'b0);
    gen_word(w); send(w ^ 16'h3FFF, 1'b0);
    check("sat_14", 64'(err_count_s), 64'd14);
    gen_word(w); send(w ^ 16'h0007, 1'b0);
    check("sat_15", 64'(err_count_s), 64'd15);
    check("nosat_17", 64'(err_count), 64'd17);
    gen_word(w); send(w ^ 16'h0003, 1'b1);
    check("clr_upd_s", 64'(err_count_s), 64'd2);
    check("clr_upd_a", 64'(err_count), 64'd2);
    gen_word(w); send(w, 1'b0);

    // Reset while locked, in-flight word discarded
    gen_word(w);
    step(1'b1, w ^ 16'h00F0, 1'b0, 1'b1);
    check("midrst_locked", 64'(locked), 64'd0);
    check("midrst_err_valid", 64'(err_valid), 64'd0);
    check("midrst_err_bits", 64'(err_bits), 64'd0);
    check("midrst_err_count", 64'(err_count), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      gen_word(w);
      send(w, 1'b0);
      if (k == 4) check("relock_not_yet", 64'(locked), 64'd0);
      if (k == 5) check("relock_locked", 64'(locked), 64'd1);
    end

    // Random traffic against the model
    burst = 0;
    for (int n = 0; n < 400; n++) begin
      logic [15:0] m;
      m = '0;
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 16'($urandom), ($urandom_range(0, 19) == 0), 1'b0);
      end else begin
        gen_word(w);
        if (burst > 0) begin
          m = 16'hFFFF; burst--;
        end else if ($urandom_range(0, 39) == 0) begin
          m = 16'hFFFF; burst = int'($urandom_range(1, 4));
        end else if ($urandom_range(0, 7) == 0) begin
          m = 16'h0001 << $urandom_range(0, 15);
        end
        step(1'b1, w ^ m, ($urandom_range(0, 19) == 0), 1'b0);
      end
    end

    // All-zero stream never locks
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      send(16'h0000, 1'b0);
      check("zero_locked", 64'(locked), 64'd0);
      check("zero_err_valid", 64'(err_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
